// File: rtl/shift_seq_32.sv
// Multi-cycle right-shift sequencer. A single-step shifter is applied once
// per cycle until the requested amount has been shifted out, which trades
// latency (shamt+1 cycles) for the area of a full barrel shifter.
`timescale 1ns/1ps

// Single-step right shifter: passes x through, or shifts it right by one
// position with zero or sign fill.
module shifter_32 (
    input  logic [31:0] x,
    input  logic        shamt,
    input  logic        arith,
    output logic [31:0] z
);
    logic [31:0] shr;

    // Lower bits take their left neighbour; nothing wraps around.
    generate
        for (genvar gi = 0; gi < 31; gi++) begin : g_step
            assign shr[gi] = x[gi+1];
        end
    endgenerate

    // Top bit is the sign for arithmetic shifts, zero otherwise.
    assign shr[31] = arith & x[31];
    assign z       = shamt ? shr : x;
endmodule

module shift_seq_32 #(
    parameter int DATA_W = 32,  // must stay 32: tied to shifter_32
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x,
    input  logic [CNT_W-1:0]  shamt,
    input  logic              arith,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] z
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic              arith_reg, arith_next;
    logic [DATA_W-1:0] z_reg,     z_next;
    logic [DATA_W-1:0] step_z;

    // One-position step applied to the working register every SHIFT cycle.
    shifter_32 u_step (
        .x     (data_reg),
        .shamt (1'b1),
        .arith (arith_reg),
        .z     (step_z)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            arith_reg <= 1'b0;
            z_reg     <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            arith_reg <= arith_next;
            z_reg     <= z_next;
        end
    end

    // Next-state and datapath updates. z is loaded with the final value on
    // the edge that enters DONE, so it is already valid while done is high.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        arith_next = arith_reg;
        z_next     = z_reg;
        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new request just like IDLE (back-to-back).
                state_next = IDLE;
                if (start) begin
                    data_next  = x;
                    cnt_next   = shamt;
                    arith_next = arith;
                    if (shamt == '0) begin
                        state_next = DONE;
                        z_next     = x;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // cnt is at least 1 here, so the decrement never wraps.
                data_next = step_z;
                cnt_next  = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                    z_next     = step_z;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign z    = z_reg;
endmodule

// File: tb/tb_shift_seq_32.sv
// Directed bench for shift_seq_32: table of single operations plus
// hand-written sequences for ignored starts, back-to-back and reset abort.
`timescale 1ns/1ps

module tb_shift_seq_32;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] z;

    int checks = 0;
    int errors = 0;

    shift_seq_32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation (caller is 1 time unit after an edge), scramble the
    // inputs after acceptance, then measure latency, busy length and result.
    task automatic do_op(input logic [31:0] vx, input logic [4:0] vsh, input logic va,
                         input logic [31:0] vexp, input string tag);
        int lat;
        int bc;
        bit seen;
        bit overlap;
        start = 1'b1; x = vx; shamt = vsh; arith = va;
        tick();
        start = 1'b0; x = ~vx; shamt = 5'd7; arith = ~va;
        lat = 1; bc = 0; seen = 1'b0; overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            tick();
            lat++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(vsh) + 32'd1);
        check({tag, " busy_cycles"}, 32'(bc), 32'(vsh));
        check({tag, " z"}, z, vexp);
        check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
        $display("op %s x=%h shamt=%0d arith=%0d z=%h lat=%0d", tag, vx, vsh, va, z, lat);
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " z_hold"}, z, vexp);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  seen;
        string nm;

        vecs[0]  = '{32'h0000000A, 5'd1,  1'b0, 32'h00000005};
        vecs[1]  = '{32'h80000000, 5'd4,  1'b1, 32'hF8000000};
        vecs[2]  = '{32'h80000000, 5'd4,  1'b0, 32'h08000000};
        vecs[3]  = '{32'h12345678, 5'd0,  1'b0, 32'h12345678};
        vecs[4]  = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
        vecs[5]  = '{32'hFFFFFFFF, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[6]  = '{32'h12345678, 5'd4,  1'b0, 32'h01234567};
        vecs[7]  = '{32'h87654321, 5'd8,  1'b1, 32'hFF876543};
        vecs[8]  = '{32'h87654321, 5'd8,  1'b0, 32'h00876543};
        vecs[9]  = '{32'h12345678, 5'd0,  1'b1, 32'h12345678};
        vecs[10] = '{32'h40000000, 5'd30, 1'b0, 32'h00000001};

        // Reset with start asserted: reset must win.
        rst = 1'b1; start = 1'b1; x = 32'hDEADBEEF; shamt = 5'd3; arith = 1'b0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset z", z, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("post_reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            nm = $sformatf("vec%0d", i);
            do_op(vecs[i].x, vecs[i].sh, vecs[i].ar, vecs[i].exp, nm);
        end

        // Start during busy is ignored; then a start in the DONE cycle.
        start = 1'b1; x = 32'h00000001; shamt = 5'd3; arith = 1'b0;
        tick();
        start = 1'b1; x = 32'hFFFF0000; shamt = 5'd2; arith = 1'b1;
        tick();
        start = 1'b0;
        lat = 2; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        check("ignore done_seen", 32'(seen), 32'd1);
        check("ignore latency", 32'(lat), 32'd4);
        check("ignore z", z, 32'h00000000);
        $display("op ignore_busy_start z=%h lat=%0d", z, lat);
        start = 1'b1; x = 32'h0000000A; shamt = 5'd1; arith = 1'b0;
        tick();
        start = 1'b0; x = 32'h0;
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b done_low", 32'(done), 32'd0);
        check("b2b z_hold", z, 32'h00000000);
        tick();
        check("b2b done", 32'(done), 32'd1);
        check("b2b z", z, 32'h00000005);
        $display("op back_to_back z=%h", z);
        tick();

        // Reset in the middle of a long shift aborts it.
        start = 1'b1; x = 32'hFFFFFFFF; shamt = 5'd10; arith = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort z", z, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check("abort no_done", 32'(seen), 32'd0);
        $display("op reset_abort z=%h", z);
        do_op(32'hF0F0F0F0, 5'd4, 1'b1, 32'hFF0F0F0F, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
